// File: rtl/seq_fsm_prog_mo.sv
// Programmable table-driven Moore FSM.
// Next-state and output tables are written at run time through the cfg port.
module seq_fsm_prog_mo #(
  parameter int p_nstates   = 4,
  parameter int p_nbits_in  = 2,
  parameter int p_nbits_out = 1,
  localparam int c_nbits_state =
    ($clog2(p_nstates) > 1) ? $clog2(p_nstates) : 1,
  localparam int c_nbits_data =
    (c_nbits_state > p_nbits_out) ? c_nbits_state : p_nbits_out
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [p_nbits_in-1:0]    in_,
  input  logic                     cfg_ns_en,
  input  logic                     cfg_out_en,
  input  logic [c_nbits_state-1:0] cfg_state,
  input  logic [p_nbits_in-1:0]    cfg_in_,
  input  logic [c_nbits_data-1:0]  cfg_data,
  output logic [c_nbits_state-1:0] state,
  output logic [p_nbits_out-1:0]   out,
  output logic                     cfg_err
);

  // Rows sized to the full index range so any state code indexes safely.
  localparam int c_nrows = 1 << c_nbits_state;
  localparam int c_ncols = 1 << p_nbits_in;
  localparam logic [c_nbits_state:0] c_lim =
    (c_nbits_state + 1)'(p_nstates);

  logic [c_nbits_state-1:0] ns_table [c_nrows][c_ncols];
  logic [p_nbits_out-1:0]   out_table [c_nrows];

  logic [c_nbits_state-1:0] ns_data;
  logic                     row_bad;
  logic                     data_bad;
  logic                     unused_ok;

  assign ns_data   = cfg_data[c_nbits_state-1:0];
  assign row_bad   = {1'b0, cfg_state} >= c_lim;
  assign data_bad  = {1'b0, ns_data} >= c_lim;
  assign unused_ok = ^cfg_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= '0;
      cfg_err <= 1'b0;
      for (int r = 0; r < c_nrows; r++) begin
        for (int c = 0; c < c_ncols; c++) begin
          ns_table[r][c] <= c_nbits_state'(r);
        end
        out_table[r] <= '0;
      end
    end else begin
      // Step reads the table before this cycle's writes land.
      if (en) begin
        state <= ns_table[state][in_];
      end
      if (cfg_ns_en) begin
        if (row_bad || data_bad) begin
          cfg_err <= 1'b1;
        end else begin
          ns_table[cfg_state][cfg_in_] <= ns_data;
        end
      end
      if (cfg_out_en) begin
        if (row_bad) begin
          cfg_err <= 1'b1;
        end else begin
          out_table[cfg_state] <= cfg_data[p_nbits_out-1:0];
        end
      end
    end
  end

  assign out = out_table[state];

endmodule

// File: tb/tb_seq_fsm_prog_mo.sv
// Bench for seq_fsm_prog_mo: a 4-state and a 3-state instance share stimulus
// and are checked every cycle against a table model, plus directed literals.
module tb_seq_fsm_prog_mo;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] in_;
  logic       cfg_ns_en;
  logic       cfg_out_en;
  logic [1:0] cfg_state;
  logic [1:0] cfg_in_;
  logic [1:0] cfg_data;

  logic [1:0] state4, state3;
  logic       out4, out3;
  logic       err4, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_fsm_prog_mo #(.p_nstates(4), .p_nbits_in(2), .p_nbits_out(1)) dut (
    .clk(clk), .reset(reset), .en(en), .in_(in_),
    .cfg_ns_en(cfg_ns_en), .cfg_out_en(cfg_out_en),
    .cfg_state(cfg_state), .cfg_in_(cfg_in_), .cfg_data(cfg_data),
    .state(state4), .out(out4), .cfg_err(err4)
  );

  seq_fsm_prog_mo #(.p_nstates(3), .p_nbits_in(2), .p_nbits_out(1)) dut3 (
    .clk(clk), .reset(reset), .en(en), .in_(in_),
    .cfg_ns_en(cfg_ns_en), .cfg_out_en(cfg_out_en),
    .cfg_state(cfg_state), .cfg_in_(cfg_in_), .cfg_data(cfg_data),
    .state(state3), .out(out3), .cfg_err(err3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 has 4 states, instance 1 has 3.
  int nst [2] = '{4, 3};
  int m_ns [2][4][4];
  int m_out [2][4];
  int m_st [2];
  int m_err [2];
  bit started = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int nxt;
      int cs, ci, cd;
      cs = int'(cfg_state);
      ci = int'(cfg_in_);
      cd = int'(cfg_data);
      if (reset) begin
        m_st[k]  = 0;
        m_err[k] = 0;
        for (int s = 0; s < 4; s++) begin
          for (int i = 0; i < 4; i++) m_ns[k][s][i] = s;
          m_out[k][s] = 0;
        end
      end else begin
        nxt = en ? m_ns[k][m_st[k]][int'(in_)] : m_st[k];
        if (cfg_ns_en) begin
          if (cs < nst[k] && cd < nst[k]) m_ns[k][cs][ci] = cd;
          else m_err[k] = 1;
        end
        if (cfg_out_en) begin
          if (cs < nst[k]) m_out[k][cs] = cd % 2;
          else m_err[k] = 1;
        end
        m_st[k] = nxt;
      end
    end
    if (reset) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_state4", int'(state4), m_st[0]);
      chk("model_out4", int'(out4), m_out[0][m_st[0]]);
      chk("model_err4", int'(err4), m_err[0]);
      chk("model_state3", int'(state3), m_st[1]);
      chk("model_out3", int'(out3), m_out[1][m_st[1]]);
      chk("model_err3", int'(err3), m_err[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_idle();
    cfg_ns_en  = 0;
    cfg_out_en = 0;
    cfg_state  = 0;
    cfg_in_    = 0;
    cfg_data   = 0;
  endtask

  task automatic step(input int i, input int es, input int eo, input string nm);
    in_ = 2'(i);
    tick();
    chk({nm, "_state"}, int'(state4), es);
    chk({nm, "_out"}, int'(out4), eo);
  endtask

  int tbl [4][4] = '{'{0, 1, 0, 3}, '{2, 1, 0, 3}, '{0, 3, 0, 3}, '{2, 1, 0, 3}};
  int seq_in [9] = '{0, 1, 1, 0, 0, 1, 0, 1, 0};
  int seq_st [9] = '{0, 1, 1, 2, 0, 1, 2, 3, 2};

  initial begin
    reset = 1; en = 0; in_ = 0;
    cfg_idle();
    tick();
    tick();
    reset = 0;

    // Reset tables hold every state.
    en = 1;
    for (int i = 0; i < 4; i++) begin
      step(i, 0, 0, "rst_hold");
      chk("rst_err", int'(err4), 0);
    end

    // Program the classic table, out=1 only in state 3.
    en = 0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) begin
        cfg_ns_en = 1;
        cfg_state = 2'(s);
        cfg_in_   = 2'(i);
        cfg_data  = 2'(tbl[s][i]);
        tick();
      end
    end
    cfg_idle();
    cfg_out_en = 1; cfg_state = 3; cfg_data = 1;
    tick();
    cfg_idle();

    en = 1;
    for (int j = 0; j < 9; j++)
      step(seq_in[j], seq_st[j], seq_st[j] == 3 ? 1 : 0, "classic");

    // en gating, now in state 2.
    en = 0;
    for (int j = 0; j < 3; j++) step(3, 2, 0, "en_hold");
    en = 1;
    step(3, 3, 1, "en_go");

    // Same-cycle write/step uses the old entry.
    step(1, 1, 0, "to_s1");
    cfg_ns_en = 1; cfg_state = 1; cfg_in_ = 1; cfg_data = 3;
    step(1, 1, 0, "rbw_old");
    cfg_idle();
    step(1, 3, 1, "rbw_new");

    // Reset mid-run reverts the table to hold.
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_state", int'(state4), 0);
    chk("midrst_out", int'(out4), 0);
    step(1, 0, 0, "midrst_hold");

    // Illegal writes on the 3-state instance.
    chk("ill_err_init", int'(err3), 0);
    cfg_out_en = 1; cfg_state = 3; cfg_data = 1;
    en = 0;
    tick();
    cfg_idle();
    chk("ill_row_err3", int'(err3), 1);
    chk("ill_row_err4", int'(err4), 0);
    cfg_ns_en = 1; cfg_state = 0; cfg_in_ = 0; cfg_data = 3;
    tick();
    cfg_idle();
    chk("ill_data_err3", int'(err3), 1);
    en = 1; in_ = 0;
    tick();
    chk("ill_data_state3", int'(state3), 0);
    reset = 1;
    tick();
    reset = 0;
    chk("ill_rst_err3", int'(err3), 0);

    // Random traffic, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      en         = ($urandom_range(0, 3) != 0);
      in_        = 2'($urandom_range(0, 3));
      cfg_ns_en  = ($urandom_range(0, 3) == 0);
      cfg_out_en = ($urandom_range(0, 5) == 0);
      cfg_state  = 2'($urandom_range(0, 3));
      cfg_in_    = 2'($urandom_range(0, 3));
      cfg_data   = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 0;
    cfg_idle();
    tick();
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_fsm_prog_mo.md
Name: seq_fsm_prog_mo

Overview:
Programmable, table-driven Moore FSM. It generalises the fixed 4-state, 2-input, 1-output table FSMs to parametrised state count, input width and output width. The next-state and output tables are RAM-like arrays, loaded at run time through a config port. It serves as the reusable sequencer/pattern-detector core for control blocks whose transition table is not known at synthesis time.

Parameters:
p_nstates, 4, number of states; legal range 2..16; state encoding 0..p_nstates-1.
p_nbits_in, 2, width of in_; legal range 1..4; the table has p_nstates*2^p_nbits_in next-state entries.
p_nbits_out, 1, width of out; legal range 1..8.
Derived: c_nbits_state = max(1, $clog2(p_nstates)).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
en  input  1  advance enable; state updates only when high
in_  input  p_nbits_in  FSM input, sampled at rising edge when en=1
cfg_ns_en  input  1  write one next-state entry this cycle
cfg_out_en  input  1  write one output entry this cycle
cfg_state  input  c_nbits_state  config row (source state)
cfg_in_  input  p_nbits_in  config column (input value); used by next-state writes only
cfg_data  input  max(c_nbits_state,p_nbits_out)  write data; low bits used per write type
state  output  c_nbits_state  current state register
out  output  p_nbits_out  Moore output = out_table[state]
cfg_err  output  1  sticky flag for an illegal config write

Behaviour:
- One clock: clk. Reset is synchronous and active-high, sampled on the rising edge of clk. There is no asynchronous path.
- On reset:
  - state=0 and cfg_err=0.
  - Every ns_table[s][i] = s, so the FSM holds in every state.
  - Every out_table[s] = 0.
  - Reset overrides en and all cfg writes in the same cycle. Reset mid-operation discards any programmed table.
- State update at rising edge when !reset && en: state <= ns_table[state][in_]. When en=0, state holds.
- Moore output: out = out_table[state], combinational from the registered state and table. No dependence on in_. Zero-cycle latency from state.
- Next-state write at rising edge when cfg_ns_en && !reset:
  - Action: ns_table[cfg_state][cfg_in_] <= cfg_data[c_nbits_state-1:0].
  - Ignored, with cfg_err<=1, if cfg_state >= p_nstates or the data value >= p_nstates. Only possible when p_nstates is not a power of two.
- Output write at rising edge when cfg_out_en && !reset:
  - Action: out_table[cfg_state] <= cfg_data[p_nbits_out-1:0].
  - Ignored, with cfg_err<=1, if cfg_state >= p_nstates.
- Both write enables high in one cycle: both writes occur; each is checked independently.
- Read-before-write: an en step in the same cycle as a write to the current entry uses the OLD table value. After the edge, out reflects the new out_table immediately, because it is combinational.
- Illegal state is unreachable; the table only ever holds legal values. cfg_err stays set until reset.
- Widths: no arithmetic. All indices are zero-extended and compared unsigned.

Test Plan:
- Reset defaults (p_nstates=4): after reset, drive en=1 with in_=00,01,10,11 -> state stays 0, out=0, cfg_err=0 every cycle.
- Program the classic table, out=1 only in state 3:
  - Rows, listed for in_=00/01/10/11: s0 0/1/0/3; s1 2/1/0/3; s2 0/3/0/3; s3 2/1/0/3.
  - Drive in_=00,01,01,00,00,01,00,01,00.
  - Required states: 0,1,1,2,0,1,2,3,2. Required out: 0,0,0,0,0,0,0,1,0.
- en gating: with the table above, hold en=0 for 3 cycles with in_=11 -> state unchanged. Then en=1, in_=11 -> state=3, out=1.
- Same-cycle write/step: in state 1, write ns_table[1][01]=3 while en=1, in_=01 -> state=1 (old entry). Next cycle in_=01 -> state=3.
- Illegal config with p_nstates=3: write cfg_state=3 -> table unchanged, cfg_err=1. Then a next-state write with cfg_data=3 -> ignored, cfg_err stays 1. Reset -> cfg_err=0.
- Reset mid-run: in state 3 with the programmed table, assert reset 1 cycle -> state=0, out=0. Then in_=01 -> state stays 0, because the table reverted to hold.
